// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for the ring-oscillator edge-count measurement slice.
package ring_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int SYNC_STAGES       = 2;

    // The shared down-counter must hold both SETTLE_CYCLES-1 (up to 14) and window-1.
    function automatic int ctr_width(input int win_w);
        return (win_w > 4) ? win_w : 4;
    endfunction

endpackage

// File: rtl/ring_edge_counter_sync_edge_detect.sv
// Synchroniser for an asynchronous probe input followed by a one-cycle rising-edge pulse.
module sync_edge_detect
    import ring_meas_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    // sh_q[0..SYNC_STAGES-1] form the synchroniser; the top bit is the delayed copy.
    logic [SYNC_STAGES:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[SYNC_STAGES-1:0], async_in};
        end
    end

    assign pulse = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];

endmodule

// File: rtl/ring_edge_counter.sv
// Enables the adder ring oscillator and counts its rising edges over a programmable
// window of wb_clk_i cycles, returning a saturating count with a sticky overflow flag.
module ring_edge_counter
    import ring_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_W         = DEF_WIN_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             active,
    input  logic             start,
    input  logic [WIN_W-1:0] window_cycles,
    input  logic             chain_in,
    output logic             ring_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output state_t           dbg_state
);

    localparam int CTR_W = ctr_width(WIN_W);

    state_t             state_q;
    state_t             state_d;
    logic [CTR_W-1:0]   ctr_q;
    logic [CTR_W-1:0]   ctr_d;
    logic [WIN_W-1:0]   win_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               pulse;
    logic               accept;

    sync_edge_detect u_sync (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .async_in (chain_in),
        .pulse    (pulse)
    );

    // Request protocol: start is a one-cycle strobe taken only when active is high and the
    // FSM sits in IDLE or DONE; there is no back-pressure, a strobe while busy is dropped.
    assign accept = active && start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // ctr_q holds "cycles remaining minus one" in SETTLE and COUNT.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = SETTLE;
                        ctr_d   = CTR_W'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (ctr_q == '0) begin
                        if (win_q == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = COUNT;
                            ctr_d   = CTR_W'(win_q) - CTR_W'(1);
                        end
                    end else begin
                        ctr_d = ctr_q - CTR_W'(1);
                    end
                end
                COUNT: begin
                    if (ctr_q == '0) begin
                        state_d = DONE;
                    end else begin
                        ctr_d = ctr_q - CTR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= window_cycles;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (!active || accept) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if ((state_q == COUNT) && pulse) begin
            if (count_q == '1) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign busy        = (state_q == SETTLE) || (state_q == COUNT);
    assign ring_enable = busy;
    assign done        = (state_q == DONE);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ring_edge_counter.sv
// Randomised self-checking bench for ring_edge_counter: a full-width and a 4-bit saturating
// instance share stimulus and are compared against an edge-list model of the window rules.
`timescale 1ns/1ps
module tb_ring_edge_counter;
  import ring_meas_pkg::*;

  localparam int S = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        active = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window_cycles = '0;
  logic        chain_in = 1'b0;

  logic        ring_enable, busy, done, overflow;
  logic [15:0] count;
  state_t      dbg_state;
  logic        ring_enable_s, busy_s, done_s, overflow_s;
  logic [3:0]  count_s;
  state_t      dbg_state_s;

  ring_edge_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(S)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .start(start),
    .window_cycles(window_cycles), .chain_in(chain_in), .ring_enable(ring_enable),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .dbg_state(dbg_state)
  );

  ring_edge_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(S)) dut_s (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .active(active), .start(start),
    .window_cycles(window_cycles), .chain_in(chain_in), .ring_enable(ring_enable_s),
    .busy(busy_s), .done(done_s), .count(count_s), .overflow(overflow_s), .dbg_state(dbg_state_s)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference record: edge number of every rising edge of chain_in as seen at a clock edge.
  int  cyc = 0;
  int  rise_q[$];
  logic chain_prev = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      chain_prev = 1'b0;
    end else begin
      if (chain_in && !chain_prev) rise_q.push_back(cyc);
      chain_prev = chain_in;
    end
  end

  function automatic int rises_in(input int lo, input int hi);
    int n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
    return n;
  endfunction

  // chain_in driver: 0 = held low, 1 = square wave toggling every `half` clocks, 2 = random bits
  int chain_mode = 0;
  int half = 4;
  int phase = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (chain_mode)
        0: chain_in = 1'b0;
        1: begin
          phase++;
          if (phase >= half) begin
            phase = 0;
            chain_in = ~chain_in;
          end
        end
        default: chain_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {29'd0, ring_enable, busy, done}, 32'd0);
    chk({tag, "_flags_s"}, {29'd0, ring_enable_s, busy_s, done_s}, 32'd0);
    chk({tag, "_cnt"}, 32'(count), 32'd0);
    chk({tag, "_cnt_s"}, 32'(count_s), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_ovf_s"}, 32'(overflow_s), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Driver: one measurement of window w; inject_off >= 0 strobes a stray start (window 10) then.
  // A rising edge sampled at edge k is counted iff k lies in [t+S-1, t+S+w-2]: it needs three
  // cycles to reach the counter and those must all fall inside the COUNT window.
  task automatic measure(input string tag, input int w, input int inject_off);
    int t;
    int exp_n;
    logic [2:0] exp_flags;
    window_cycles = 16'(w);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    window_cycles = 16'($urandom);
    t = cyc;
    for (int o = 0; o <= S + w; o++) begin
      if (o > 0) begin
        @(posedge clk); #1;
      end
      if (o == inject_off) begin
        start = 1'b1;
        window_cycles = 16'd10;
      end else begin
        start = 1'b0;
      end
      if (o == 0) begin
        chk({tag, "_clr_cnt"}, 32'(count), 32'd0);
        chk({tag, "_clr_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_clr_cnt_s"}, 32'(count_s), 32'd0);
        chk({tag, "_clr_ovf_s"}, 32'(overflow_s), 32'd0);
      end
      exp_flags = (o < S + w) ? 3'b110 : 3'b001;
      chk({tag, "_flags"}, {29'd0, ring_enable, busy, done}, {29'd0, exp_flags});
      chk({tag, "_flags_s"}, {29'd0, ring_enable_s, busy_s, done_s}, {29'd0, exp_flags});
    end
    start = 1'b0;
    exp_n = rises_in(t + S - 1, t + S + w - 2);
    chk({tag, "_count"}, 32'(count), 32'(exp_n));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_n > 65535));
    chk({tag, "_count_s"}, 32'(count_s), 32'((exp_n > 15) ? 15 : exp_n));
    chk({tag, "_ovf_s"}, 32'(overflow_s), 32'(exp_n > 15));
  endtask

  task automatic abort_run();
    logic seen;
    window_cycles = 16'd64;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int o = 1; o <= S + 20; o++) begin
      @(posedge clk); #1;
    end
    active = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("abort");
    active = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      seen = seen | done | busy | done_s | busy_s;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
  endtask

  task automatic reset_run();
    window_cycles = 16'd64;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int o = 1; o <= S + 10; o++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int inj;
    active = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    chain_mode = 1; half = 4;
    measure("basic", 64, -1);
    measure("zero", 0, -1);
    half = 2;
    measure("sat", 100, -1);
    measure("restart", 20, -1);
    half = 4;
    measure("busy_start", 64, S + 10);
    half = 2;
    abort_run();
    half = 4;
    reset_run();
    measure("post_rst", 64, -1);

    for (int n = 0; n < 25; n++) begin
      chain_mode = $urandom_range(1, 2);
      half = $urandom_range(1, 6);
      w = $urandom_range(0, 150);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, S + w - 1)) : -1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      measure("rand", w, inj);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
